// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS generator and checker.
// Polynomial x^8+x^4+x^3+x^2+1, generator reset seed 0x80, period 255.
package lfsr_pkg;

  localparam int          LFSR_W    = 8;
  localparam logic [7:0]  LFSR_TAPS = 8'b1000_1110;
  localparam logic [7:0]  LFSR_SEED = 8'h80;

  // Checker synchronisation states
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One LFSR step: shift left, feedback is the parity of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: hunts for a seed, verifies LOCK_THRESH
// consecutive predicted bytes, then counts matching/erroneous bytes while
// locked. Lock drops after LOSS_THRESH consecutive mismatches.
// Optional macro LFSR_CHK_STRICT_SEED_EN: only the generator reset value
// (0x80) may seed the checker, so sequence phase is verified as well.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_THRESH - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

  chk_state_t        state_r, state_s;
  logic [7:0]        expected_r, expected_s;
  logic [RUN_W-1:0]  run_r, run_s;
  logic [MISS_W-1:0] miss_r, miss_s;
  logic              locked_s;
  logic              err_pulse_s;
  logic              match_evt_s;
  logic              err_evt_s;
  logic              seed_ok_s;
  logic [CNT_W-1:0]  err_cnt_s, match_cnt_s;

`ifdef LFSR_CHK_STRICT_SEED_EN
  assign seed_ok_s = (in_data == LFSR_SEED);
`else
  assign seed_ok_s = (in_data != 8'h00);
`endif

  // Next-state logic for the sync FSM, predictor, run/miss counters and strobes
  always_comb begin
    state_s     = state_r;
    expected_s  = expected_r;
    run_s       = run_r;
    miss_s      = miss_r;
    locked_s    = locked;
    err_pulse_s = 1'b0;
    match_evt_s = 1'b0;
    err_evt_s   = 1'b0;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (seed_ok_s) begin
            expected_s = lfsr_next(in_data);
            run_s      = '0;
            state_s    = VERIFY;
          end else begin
            state_s    = HUNT;
          end
        end
        VERIFY: begin
          if (in_data == expected_r) begin
            expected_s = lfsr_next(in_data);
            run_s      = run_r + RUN_W'(1);
            if (run_r == RUN_LAST) begin
              state_s  = LOCKED;
              locked_s = 1'b1;
              miss_s   = '0;
            end else begin
              state_s  = VERIFY;
            end
          end else if (seed_ok_s) begin
            // Re-seed straight from the offending byte
            expected_s = lfsr_next(in_data);
            run_s      = '0;
            state_s    = VERIFY;
          end else begin
            state_s    = HUNT;
          end
        end
        LOCKED: begin
          // Predictor free-runs so one corrupted byte costs exactly one error
          expected_s = lfsr_next(expected_r);
          if (in_data == expected_r) begin
            match_evt_s = 1'b1;
            miss_s      = '0;
          end else begin
            err_evt_s   = 1'b1;
            err_pulse_s = 1'b1;
            miss_s      = miss_r + MISS_W'(1);
            if (miss_r == MISS_LAST) begin
              state_s  = HUNT;
              locked_s = 1'b0;
              miss_s   = '0;
            end else begin
              state_s  = LOCKED;
            end
          end
        end
        default: begin
          state_s  = HUNT;
          locked_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Saturating counters; a clear in the same cycle discards the event
  always_comb begin
    err_cnt_s   = err_cnt;
    match_cnt_s = match_cnt;
    if (clr_cnt) begin
      err_cnt_s   = '0;
      match_cnt_s = '0;
    end else begin
      if (err_evt_s && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt_s = err_cnt + CNT_W'(1);
      end else begin
        err_cnt_s = err_cnt;
      end
      if (match_evt_s && (match_cnt != {CNT_W{1'b1}})) begin
        match_cnt_s = match_cnt + CNT_W'(1);
      end else begin
        match_cnt_s = match_cnt;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= HUNT;
      expected_r <= 8'h00;
      run_r      <= '0;
      miss_r     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      match_cnt  <= '0;
    end else begin
      state_r    <= state_s;
      expected_r <= expected_s;
      run_r      <= run_s;
      miss_r     <= miss_s;
      locked     <= locked_s;
      err_pulse  <= err_pulse_s;
      err_cnt    <= err_cnt_s;
      match_cnt  <= match_cnt_s;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed vector table, a hand-written
// saturation/clear sequence on a narrow-counter instance, and random stimulus
// compared against a sequence-position reference model.
module tb_lfsr_checker;

`ifdef LFSR_CHK_STRICT_SEED_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clr_cnt = 1'b0;

  logic        locked0, ep0;
  logic [15:0] err0, mat0;
  logic        locked1, ep1;
  logic [3:0]  err1, mat1;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked0), .err_pulse(ep0), .err_cnt(err0), .match_cnt(mat0));

  lfsr_checker #(.LOCK_THRESH(4), .LOSS_THRESH(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked1), .err_pulse(ep1), .err_cnt(err1), .match_cnt(mat1));

  int checks = 0;
  int failures = 0;

  // PRBS sequence table and inverse lookup (position of each nonzero byte)
  int seq [255];
  int pos_of [256];

  // Reference model: tracks where in the 255-long sequence the next byte sits
  typedef struct {
    int st; int idx; int run; int miss;
    bit locked; bit ep; int err; int mat;
    int lock_th; int loss_th; int cmax;
  } mdl_t;
  mdl_t m0, m1;

  typedef struct {
    bit r; bit v; logic [7:0] d; bit c;
    bit locked; bit ep; int err; int mat;
  } vec_t;
  vec_t vecs [$];

  function automatic bit seed_ok(int d);
    if (STRICT) return d == 8'h80;
    return d != 0;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit r, bit v, int d, bit c);
    mdl_t n = m;
    bit cm = 1'b0, ce = 1'b0;
    n.ep = 1'b0;
    if (r) begin
      n.st = 0; n.idx = 0; n.run = 0; n.miss = 0;
      n.locked = 1'b0; n.err = 0; n.mat = 0;
      return n;
    end
    if (v) begin
      if (m.st == 0) begin
        if (seed_ok(d)) begin n.idx = (pos_of[d] + 1) % 255; n.run = 0; n.st = 1; end
      end else if (m.st == 1) begin
        if (d == seq[m.idx]) begin
          n.idx = (m.idx + 1) % 255; n.run = m.run + 1;
          if (n.run == m.lock_th) begin n.st = 2; n.locked = 1'b1; n.miss = 0; end
        end else if (seed_ok(d)) begin
          n.idx = (pos_of[d] + 1) % 255; n.run = 0;
        end else begin
          n.st = 0;
        end
      end else begin
        n.idx = (m.idx + 1) % 255;
        if (d == seq[m.idx]) begin cm = 1'b1; n.miss = 0; end
        else begin
          ce = 1'b1; n.ep = 1'b1; n.miss = m.miss + 1;
          if (n.miss == m.loss_th) begin n.st = 0; n.locked = 1'b0; n.miss = 0; end
        end
      end
    end
    if (c) begin n.err = 0; n.mat = 0; end
    else begin
      if (ce && n.err < m.cmax) n.err = n.err + 1;
      if (cm && n.mat < m.cmax) n.mat = n.mat + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one beat, advance the models with it, sample just after the edge
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; clr_cnt = c;
    @(posedge clk);
    m0 = mstep(m0, r, v, int'(d), c);
    m1 = mstep(m1, r, v, int'(d), c);
    #1;
  endtask

  function automatic void addv(bit r, bit v, logic [7:0] d, bit c, bit lk, bit ep, int err, int mat);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.c = c; x.locked = lk; x.ep = ep; x.err = err; x.mat = mat;
    vecs.push_back(x);
  endfunction

  initial begin
    int s;
    int gen;
    logic [7:0] bytes_lock [5];
    bytes_lock[0] = 8'h80; bytes_lock[1] = 8'h01; bytes_lock[2] = 8'h02;
    bytes_lock[3] = 8'h05; bytes_lock[4] = 8'h0B;

    // Build the sequence from the polynomial taps x^8,x^4,x^3,x^2
    s = 8'h80;
    for (int i = 0; i < 256; i++) pos_of[i] = -1;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s;
      pos_of[s] = i;
      s = ((s << 1) & 8'hFF) | (((s >> 7) ^ (s >> 3) ^ (s >> 2) ^ (s >> 1)) & 1);
    end
    chk("seq_period", s, 8'h80);

    m0 = '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 4, 3, 65535};
    m1 = '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 4, 32, 15};

    // ---------------- directed vector table (default instance) -----------
    addv(1, 0, 8'h00, 0, 0, 0, 0, 0);           // reset state
    addv(0, 1, 8'h80, 0, 0, 0, 0, 0);           // lock sequence
    addv(0, 1, 8'h01, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h02, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h05, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h0B, 0, 1, 0, 0, 0);           // locked after 4th match
    addv(0, 1, 8'h17, 0, 1, 1, 1, 0);           // single error (0x16 expected)
    addv(0, 1, 8'h2C, 0, 1, 0, 1, 1);           // free-run continues
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0);           // clear, lock kept
    addv(0, 1, 8'hFF, 0, 1, 1, 1, 0);           // loss of lock
    addv(0, 1, 8'hFF, 0, 1, 1, 2, 0);
    addv(0, 1, 8'hFF, 0, 0, 1, 3, 0);
    addv(0, 0, 8'h00, 0, 0, 0, 3, 0);
    addv(0, 1, 8'h05, 0, 0, 0, 3, 0);           // re-seed (ignored when strict)
    addv(0, 1, 8'h0B, 0, 0, 0, 3, 0);
    addv(0, 1, 8'h16, 0, 0, 0, 3, 0);
    addv(0, 1, 8'h2C, 0, 0, 0, 3, 0);
    addv(0, 1, 8'h58, 0, !STRICT, 0, 3, 0);
    addv(1, 0, 8'h00, 0, 0, 0, 0, 0);           // zero/idle handling in HUNT
    addv(0, 1, 8'h00, 0, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h00, 0, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h00, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) addv(0, 1, bytes_lock[i], 0, i == 4, 0, 0, 0);
    addv(1, 1, 8'h16, 0, 0, 0, 0, 0);           // reset while locked
    addv(0, 1, 8'h05, 0, 0, 0, 0, 0);           // stream not starting at seed
    addv(0, 1, 8'h0B, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h16, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h2C, 0, 0, 0, 0, 0);
    addv(0, 1, 8'h58, 0, !STRICT, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].c);
      chk($sformatf("vec%0d_locked", i), int'(locked0), int'(vecs[i].locked));
      chk($sformatf("vec%0d_err_pulse", i), int'(ep0), int'(vecs[i].ep));
      chk($sformatf("vec%0d_err_cnt", i), int'(err0), vecs[i].err);
      chk($sformatf("vec%0d_match_cnt", i), int'(mat0), vecs[i].mat);
    end

    // ---------------- saturation and clear (4-bit counters) --------------
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, bytes_lock[i], 0);
    chk("sat_locked_start", int'(locked1), 1);
    for (int i = 0; i < 20; i++) step(0, 1, 8'h00, 0);
    chk("sat_err_cnt", int'(err1), 15);
    chk("sat_err_pulse", int'(ep1), 1);
    chk("sat_locked_hold", int'(locked1), 1);
    step(0, 1, 8'h00, 1);
    chk("clr_err_cnt", int'(err1), 0);
    chk("clr_err_pulse", int'(ep1), 1);
    chk("clr_locked", int'(locked1), 1);
    step(0, 0, 8'h00, 0);
    chk("idle_err_pulse", int'(ep1), 0);
    chk("idle_err_cnt", int'(err1), 0);

    // ---------------- random stream vs reference model -------------------
    step(1, 0, 8'h00, 0);
    gen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, v, c;
      int d, p;
      r = ($urandom_range(0, 399) == 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 7) != 0);
      p = $urandom_range(0, 99);
      if (p < 86) begin d = seq[gen]; if (v) gen = (gen + 1) % 255; end
      else if (p < 90) d = 0;
      else if (p < 92) begin gen = $urandom_range(0, 254); d = seq[gen]; end
      else if (p < 94) begin d = 8'h80; gen = 1; end
      else d = $urandom_range(0, 255);
      step(r, v, d[7:0], c);
      chk("rnd_locked", int'(locked0), int'(m0.locked));
      chk("rnd_err_pulse", int'(ep0), int'(m0.ep));
      chk("rnd_err_cnt", int'(err0), m0.err);
      chk("rnd_match_cnt", int'(mat0), m0.mat);
      chk("rnd_sat_locked", int'(locked1), int'(m1.locked));
      chk("rnd_sat_err_pulse", int'(ep1), int'(m1.ep));
      chk("rnd_sat_err_cnt", int'(err1), m1.err);
      chk("rnd_sat_match_cnt", int'(mat1), m1.mat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
